layer_resource_arbiter: RTL
===========================

# layer_resource_arbiter

Round-robin arbiter that time-shares the single RAM port pair (read address, write port) and the single fixed-point multiplier among the LAYER instances of the network. It replaces the wired-OR bus sharing, which relies on idle layers driving zero, with explicit request/grant ownership, a post-release drain period for in-flight RAM reads, and a hold-time watchdog. It sits between the layer array and RAM_WRAPPER/MULT_WRAPPER. `ram_data_read` and `mult_res` stay broadcast to all layers and do not pass through this block.

## Interface
Parameters:
- `N`, 3: number of requesters (layers), at least 1.
- `INT_W`, 8: integer bits of the fixed-point number.
- `FRAC_W`, 8: fractional bits; `NUM_W = INT_W + FRAC_W`.
- `RAM_ADDR_W`, 8: RAM address width.
- `RAM_DELAY`, 1: RAM read latency in cycles; sets the drain length.
- `MAX_HOLD`, 1024: maximum cycles one owner may hold the grant; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global enable; when low, all state freezes.
- `req`  in  N  per-requester access request, level.
- `release`  in  N  per-requester release pulse; only the owner's bit is honoured.
- `rq_ram_write`  in  N  per-requester write strobe.
- `rq_ram_addr_write`  in  N*RAM_ADDR_W  flattened per-requester write addresses.
- `rq_ram_data_write`  in  N*NUM_W  flattened per-requester write data.
- `rq_ram_addr_read`  in  N*RAM_ADDR_W  flattened per-requester read addresses.
- `rq_mult_v1`, `rq_mult_v2`  in  N*NUM_W each  flattened per-requester multiplier operands.
- `grant`  out  N  one-hot grant, registered.
- `owner`  out  $clog2(N) (minimum 1)  index of the current or last owner.
- `busy`  out  1  high in OWNED or DRAIN.
- `timeout_err`  out  1  sticky; set when the watchdog revokes a grant.
- `timeout_id`  out  $clog2(N)  owner index at the last revoke.
- `ram_write`, `ram_addr_write`, `ram_data_write`, `ram_addr_read`, `mult_v1`, `mult_v2`  out  as the RAM_WRAPPER/MULT_WRAPPER inputs  the muxed shared-resource bus.

## Operation
- FSM states: IDLE, OWNED, DRAIN. Internal registers: `last` (round-robin pointer), `hold_cnt`, `drain_cnt`.
- IDLE:
  - If `enable` and `|req`, pick the first set `req` bit scanning from `(last+1) mod N` upward with wrap.
  - Register `grant` one-hot, `owner` and `last` to the winner; clear `hold_cnt`; go to OWNED.
- OWNED, each cycle `hold_cnt` increments. Exit on the first matching condition:
  - Voluntary release: `release[owner]` or `!req[owner]`. Clear `grant`; go to DRAIN with `drain_cnt = RAM_DELAY`, or to IDLE directly if `RAM_DELAY == 0`.
  - Watchdog: `MAX_HOLD != 0` and `hold_cnt == MAX_HOLD-1`. Same exit path as voluntary release, plus set `timeout_err` and load `timeout_id = owner`.
  - If release and watchdog fire in the same cycle, release wins and `timeout_err` is not set.
- DRAIN:
  - Decrement `drain_cnt`; at 1, go to IDLE.
  - No grant is issued during DRAIN, so read data returning in this window belongs to the previous owner.
- Bus mux (combinational from registered `state`/`owner`):
  - In OWNED, outputs equal the owner's slice.
  - Otherwise all bus outputs are 0; `ram_write` is therefore 0 outside OWNED.
- `release` or `rq_*` from non-owners is ignored.
- An owner that keeps `req` high after releasing re-competes. Round-robin order gives every other pending requester priority first.
- `enable` low: state, counters, `grant` and outputs hold. The watchdog does not advance.

## Timing
- Reset values: state IDLE, `grant = 0`, `owner = 0`, `last = N-1` (requester 0 wins first), `hold_cnt = 0`, `drain_cnt = 0`, `busy = 0`, `timeout_err = 0`, `timeout_id = 0`, all bus outputs 0.
- Latency:
  - `req` sampled high at edge t gives `grant` at t+1.
  - `release` sampled at edge t drops `grant` at t+1.
  - The next grant comes at the earliest at t+2+RAM_DELAY.
- Maximum hold: the grant is high for exactly `MAX_HOLD` cycles when never released.
- Reset asserted mid-ownership: grant and bus outputs clear immediately (asynchronously). There is no drain.
- `timeout_err` clears only on reset.

## Structure
- The shared network package holds `NUM_W`, the arbiter state enum (IDLE/OWNED/DRAIN) and a `clog2_min1` helper constant function.
- One sub-module, `rr_pick`: a combinational round-robin priority picker with inputs `req` and `last`, outputs `valid`, `idx` and `onehot`. Verify it separately for N = 1, 3 and 8.

## Test plan
- Single request: reset, then `req = 3'b010` → `grant = 3'b010` one cycle later and the bus equals slice 1. Release → `grant = 0` next cycle, `busy` high for 1 DRAIN cycle (RAM_DELAY = 1).
- Fairness: `req = 3'b111` held, each owner releasing after 4 cycles → grant order 0, 1, 2, 0, with exactly 1 idle drain cycle between grants.
- Watchdog: `MAX_HOLD = 8`, requester 2 never releases → grant revoked after 8 cycles, `timeout_err = 1`, `timeout_id = 2`; requester 0 pending is granted after drain.
- Isolation: non-owner drives `rq_ram_write = 1` with `addr = 8'h55` → `ram_write` stays 0 and the RAM is unchanged. Outside OWNED, `mult_v1` and `mult_v2` read 0.
- Enable/reset: `enable` dropped mid-OWNED for 5 cycles → grant held and `hold_cnt` frozen. Reset pulse mid-OWNED → `grant = 0` without waiting for a clock edge, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/layer_resource_arbiter_pkg.sv
// Shared definitions for the layer resource arbiter: number format defaults,
// arbiter state encoding and a width helper.
package layer_resource_arbiter_pkg;

   localparam int unsigned INT_W_DEF  = 8;
   localparam int unsigned FRAC_W_DEF = 8;
   localparam int unsigned NUM_W      = INT_W_DEF + FRAC_W_DEF;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWNED = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

   // Index width that never collapses to zero bits for a single requester.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_resource_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after last, with wrap-around.
module rr_pick #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic [31:0] cand;

   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(last) + k) % N;
         if (!valid && req[IDX_W'(cand)]) begin
            valid = 1'b1;
            idx   = IDX_W'(cand);
         end
      end
      if (valid) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/layer_resource_arbiter.sv
// Round-robin owner of the shared RAM port pair and multiplier, with a
// post-release drain window and a hold-time watchdog.
module layer_resource_arbiter
   import layer_resource_arbiter_pkg::*;
#(
   parameter int unsigned N          = 3,
   parameter int unsigned INT_W      = INT_W_DEF,
   parameter int unsigned FRAC_W     = FRAC_W_DEF,
   parameter int unsigned RAM_ADDR_W = 8,
   parameter int unsigned RAM_DELAY  = 1,
   parameter int unsigned MAX_HOLD   = 1024,
   localparam int unsigned NW        = INT_W + FRAC_W,
   localparam int unsigned IDX_W     = clog2_min1(N)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            release_i,
   input  logic [N-1:0]            rq_ram_write,
   input  logic [N*RAM_ADDR_W-1:0] rq_ram_addr_write,
   input  logic [N*NW-1:0]         rq_ram_data_write,
   input  logic [N*RAM_ADDR_W-1:0] rq_ram_addr_read,
   input  logic [N*NW-1:0]         rq_mult_v1,
   input  logic [N*NW-1:0]         rq_mult_v2,
   output logic [N-1:0]            grant,
   output logic [IDX_W-1:0]        owner,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [IDX_W-1:0]        timeout_id,
   output logic                    ram_write,
   output logic [RAM_ADDR_W-1:0]   ram_addr_write,
   output logic [NW-1:0]           ram_data_write,
   output logic [RAM_ADDR_W-1:0]   ram_addr_read,
   output logic [NW-1:0]           mult_v1,
   output logic [NW-1:0]           mult_v2
);

   localparam int unsigned HOLD_W    = clog2_min1(MAX_HOLD + 1);
   localparam int unsigned DRAIN_W   = clog2_min1(RAM_DELAY + 1);
   localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

   arb_state_e         state_q, state_d;
   logic [N-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               terr_q, terr_d;
   logic [IDX_W-1:0]   tid_q, tid_d;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [N-1:0]       pick_onehot;
   logic               vol_rel, wd_fire;

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .last   (last_q),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign vol_rel = release_i[owner_q] || !req[owner_q];
   assign wd_fire = (MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_LAST));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      drain_d = drain_q;
      terr_d  = terr_q;
      tid_d   = tid_q;
      if (enable) begin
         unique case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  grant_d = pick_onehot;
                  owner_d = pick_idx;
                  last_d  = pick_idx;
                  hold_d  = '0;
                  state_d = ARB_OWNED;
               end
            end
            ARB_OWNED: begin
               hold_d = hold_q + HOLD_W'(1);
               // A release coinciding with the watchdog is treated as voluntary.
               if (vol_rel || wd_fire) begin
                  grant_d = '0;
                  if (!vol_rel) begin
                     terr_d = 1'b1;
                     tid_d  = owner_q;
                  end
                  if (RAM_DELAY == 0) begin
                     state_d = ARB_IDLE;
                  end else begin
                     state_d = ARB_DRAIN;
                     drain_d = DRAIN_W'(RAM_DELAY);
                  end
               end
            end
            ARB_DRAIN: begin
               if (drain_q <= DRAIN_W'(1)) begin
                  drain_d = '0;
                  state_d = ARB_IDLE;
               end else begin
                  drain_d = drain_q - DRAIN_W'(1);
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDX_W'(N - 1);
         hold_q  <= '0;
         drain_q <= '0;
         terr_q  <= 1'b0;
         tid_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         drain_q <= drain_d;
         terr_q  <= terr_d;
         tid_q   <= tid_d;
      end
   end

   assign grant       = grant_q;
   assign owner       = owner_q;
   assign busy        = (state_q == ARB_OWNED) || (state_q == ARB_DRAIN);
   assign timeout_err = terr_q;
   assign timeout_id  = tid_q;

   always_comb begin
      ram_write      = 1'b0;
      ram_addr_write = '0;
      ram_data_write = '0;
      ram_addr_read  = '0;
      mult_v1        = '0;
      mult_v2        = '0;
      if (state_q == ARB_OWNED) begin
         ram_write      = rq_ram_write[owner_q];
         ram_addr_write = rq_ram_addr_write[32'(owner_q)*RAM_ADDR_W +: RAM_ADDR_W];
         ram_data_write = rq_ram_data_write[32'(owner_q)*NW +: NW];
         ram_addr_read  = rq_ram_addr_read[32'(owner_q)*RAM_ADDR_W +: RAM_ADDR_W];
         mult_v1        = rq_mult_v1[32'(owner_q)*NW +: NW];
         mult_v2        = rq_mult_v2[32'(owner_q)*NW +: NW];
      end
   end

endmodule
